// File: rtl/centroid_calc.sv
// centroid_calc: centroid of foreground pixels in one video frame.
//
// Sums the column, the row and the count of foreground pixels
// (pixel_in[7:0] >= THRESH) during active video. On each vsync rising edge
// the sums are handed to a sequential restoring divider, one quotient bit per
// cycle: 32 cycles for x, then 32 for y. The saturated quotients then become
// the new centre, which is held for the whole following frame. A frame with
// fewer than MIN_PIXELS foreground pixels leaves the centre unchanged.
//
// Optional build macro:
//   CENTROID_SMOOTH_EN  each update writes the average of the old centre and
//                       the new quotient, rounded up. The first update after
//                       reset loads the quotient directly.
//
// Ports:
//   clk       pixel clock
//   rst_n     asynchronous active-low reset
//   de        data enable (active video)
//   hsync     horizontal sync (unused)
//   vsync     vertical sync, high = blanking / frame boundary
//   pixel_in  mask pixel, only [7:0] is used
//   x_center  centroid column, 0..IMG_W-1
//   y_center  centroid row, 0..IMG_H-1
//   valid     one-cycle pulse in the cycle x/y_center take a new value
//   busy      high while the divider runs (DIV_X, DIV_Y, DONE)
module centroid_calc #(
  parameter int unsigned IMG_W      = 1280,
  parameter int unsigned IMG_H      = 720,
  parameter int unsigned THRESH     = 128,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel_in,
  output logic [10:0] x_center,
  output logic [10:0] y_center,
  output logic        valid,
  output logic        busy
);

  localparam logic [10:0] XMax   = 11'(IMG_W - 1);
  localparam logic [10:0] YMax   = 11'(IMG_H - 1);
  localparam logic [10:0] XRst   = 11'(IMG_W / 2);
  localparam logic [10:0] YRst   = 11'(IMG_H / 2);
  localparam logic [7:0]  Thr    = 8'(THRESH);
  localparam logic [19:0] MinCnt = 20'(MIN_PIXELS);

  typedef enum logic [1:0] {StIdle, StDivX, StDivY, StDone} state_e;

  function automatic logic [10:0] sat(input logic [31:0] q, input logic [10:0] mx);
    return (q > {21'd0, mx}) ? mx : q[10:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Position tracking and accumulation
  // ---------------------------------------------------------------------------
  logic        de_act, fg, frame_end_d;
  logic        de_q, vsync_q, frame_end_q;
  logic [10:0] x_pos_d, x_pos_q, y_pos_d, y_pos_q;
  logic [31:0] sum_x_d, sum_x_q, sum_y_d, sum_y_q;
  logic [19:0] cnt_d, cnt_q;

  // de is ignored during vertical blanking, including for edge detection.
  assign de_act      = de & ~vsync;
  assign fg          = pixel_in[7:0] >= Thr;
  assign frame_end_d = vsync & ~vsync_q;

  always_comb begin
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    if (vsync) begin
      x_pos_d = '0;
      y_pos_d = '0;
    end else if (de) begin
      x_pos_d = x_pos_q + 11'd1;
    end else if (de_q) begin
      x_pos_d = '0;
      y_pos_d = y_pos_q + 11'd1;
    end
  end

  always_comb begin
    sum_x_d = sum_x_q;
    sum_y_d = sum_y_q;
    cnt_d   = cnt_q;
    if (frame_end_q) begin
      // The divider (if idle) samples the sums in this same cycle.
      sum_x_d = '0;
      sum_y_d = '0;
      cnt_d   = '0;
    end else if (de_act && fg) begin
      sum_x_d = sum_x_q + 32'(x_pos_q);
      sum_y_d = sum_y_q + 32'(y_pos_q);
      cnt_d   = cnt_q + 20'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Restoring divider and output FSM
  // ---------------------------------------------------------------------------
  state_e      state_d, state_q;
  logic [4:0]  bit_cnt_d, bit_cnt_q;
  logic [31:0] dvd_d, dvd_q;      // dividend shifting out, quotient shifting in
  logic [19:0] rem_d, rem_q;
  logic [19:0] div_d, div_q;
  logic [31:0] sy_d, sy_q;        // y sum parked while x is divided
  logic [31:0] qx_d, qx_q;
  logic [10:0] x_center_d, x_center_q, y_center_d, y_center_q;
  logic [10:0] qx_sat, qy_sat;

  logic [20:0] trial, diff, rem_wide;
  logic        ge;
  logic [31:0] dvd_step;

  assign trial    = {rem_q, dvd_q[31]};
  assign ge       = trial >= {1'b0, div_q};
  assign diff     = trial - {1'b0, div_q};
  // Remainder stays below the divisor, so bit 20 is always zero.
  assign rem_wide = ge ? diff : trial;
  assign dvd_step = {dvd_q[30:0], ge};

`ifdef CENTROID_SMOOTH_EN
  logic        primed_d, primed_q;
  logic [11:0] x_avg, y_avg;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    div_d      = div_q;
    sy_d       = sy_q;
    qx_d       = qx_q;
    x_center_d = x_center_q;
    y_center_d = y_center_q;
    qx_sat     = sat(qx_q, XMax);
    qy_sat     = sat(dvd_step, YMax);
`ifdef CENTROID_SMOOTH_EN
    primed_d   = primed_q;
    x_avg      = 12'(x_center_q) + 12'(qx_sat) + 12'd1;
    y_avg      = 12'(y_center_q) + 12'(qy_sat) + 12'd1;
`endif
    unique case (state_q)
      StIdle: begin
        // Frames ending while the divider is busy are simply never sampled.
        if (frame_end_q && (cnt_q >= MinCnt)) begin
          dvd_d     = sum_x_q;
          sy_d      = sum_y_q;
          div_d     = cnt_q;
          rem_d     = '0;
          bit_cnt_d = '0;
          state_d   = StDivX;
        end
      end
      StDivX: begin
        dvd_d     = dvd_step;
        rem_d     = rem_wide[19:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          qx_d    = dvd_step;
          dvd_d   = sy_q;
          rem_d   = '0;
          state_d = StDivY;
        end
      end
      StDivY: begin
        dvd_d     = dvd_step;
        rem_d     = rem_wide[19:0];
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd31) begin
          state_d = StDone;
          // Written on entry to DONE so the outputs change in the valid cycle.
`ifdef CENTROID_SMOOTH_EN
          if (primed_q) begin
            x_center_d = x_avg[11:1];
            y_center_d = y_avg[11:1];
          end else begin
            x_center_d = qx_sat;
            y_center_d = qy_sat;
          end
          primed_d = 1'b1;
`else
          x_center_d = qx_sat;
          y_center_d = qy_sat;
`endif
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy     = state_q != StIdle;
  assign valid    = state_q == StDone;
  assign x_center = x_center_q;
  assign y_center = y_center_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q        <= 1'b0;
      vsync_q     <= 1'b0;
      frame_end_q <= 1'b0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      sum_x_q     <= '0;
      sum_y_q     <= '0;
      cnt_q       <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      sy_q        <= '0;
      qx_q        <= '0;
      x_center_q  <= XRst;
      y_center_q  <= YRst;
`ifdef CENTROID_SMOOTH_EN
      primed_q    <= 1'b0;
`endif
    end else begin
      de_q        <= de_act;
      vsync_q     <= vsync;
      frame_end_q <= frame_end_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      sum_x_q     <= sum_x_d;
      sum_y_q     <= sum_y_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      dvd_q       <= dvd_d;
      rem_q       <= rem_d;
      div_q       <= div_d;
      sy_q        <= sy_d;
      qx_q        <= qx_d;
      x_center_q  <= x_center_d;
      y_center_q  <= y_center_d;
`ifdef CENTROID_SMOOTH_EN
      primed_q    <= primed_d;
`endif
    end
  end

  logic unused_ok;
  assign unused_ok = ^{hsync, pixel_in[23:8], rem_wide[20]};

endmodule

// File: tb/tb_centroid_calc.sv
// Bench for centroid_calc: directed frames with hand-computed centroids.
// Expected centres are queued when a frame ends; a monitor pops and checks
// them whenever valid pulses, together with latency and busy length.
module tb_centroid_calc;

  logic        clk = 1'b0;
  logic        rst_n, de, hsync, vsync;
  logic [23:0] pixel_in;
  logic [10:0] x_center, y_center;
  logic        valid, busy;

  always #5 clk = ~clk;

  centroid_calc dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .de       (de),
    .hsync    (hsync),
    .vsync    (vsync),
    .pixel_in (pixel_in),
    .x_center (x_center),
    .y_center (y_center),
    .valid    (valid),
    .busy     (busy)
  );

  typedef struct {int x; int y; int fe;} exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, last_fe = 0;
  int busy_len = 0, busy_total = 0;
  int exp_x = 640, exp_y = 360;
`ifdef CENTROID_SMOOTH_EN
  bit primed = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Model of the output update given the true floor quotients.
  task automatic expect_update(input int qx, input int qy);
    int sx, sy;
    sx = (qx > 1279) ? 1279 : qx;
    sy = (qy > 719) ? 719 : qy;
`ifdef CENTROID_SMOOTH_EN
    if (primed) begin
      exp_x = (exp_x + sx + 1) >> 1;
      exp_y = (exp_y + sy + 1) >> 1;
    end else begin
      exp_x = sx;
      exp_y = sy;
    end
    primed = 1'b1;
`else
    exp_x = sx;
    exp_y = sy;
`endif
    sb.push_back('{exp_x, exp_y, last_fe});
  endtask

  task automatic model_reset();
    exp_x = 640;
    exp_y = 360;
`ifdef CENTROID_SMOOTH_EN
    primed = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Lines 0..h-1; in sparse mode lines outside y0..y1 are one pixel wide.
  // Ends with a vsync pulse (frame end) during which de/fg are driven and
  // must be ignored.
  task automatic send_frame(input int w, input int h, input int x0, input int x1,
                            input int y0, input int y1, input logic [23:0] fgv,
                            input logic [23:0] bgv, input bit sparse);
    int lw;
    for (int y = 0; y < h; y++) begin
      lw = (sparse && (y < y0 || y > y1)) ? 1 : w;
      for (int x = 0; x < lw; x++) begin
        @(negedge clk);
        de       = 1'b1;
        pixel_in = (x >= x0 && x <= x1 && y >= y0 && y <= y1) ? fgv : bgv;
      end
      @(negedge clk);
      de       = 1'b0;
      pixel_in = '0;
      hsync    = 1'b1;
      @(negedge clk);
      hsync    = 1'b0;
    end
    @(negedge clk);
    vsync   = 1'b1;
    last_fe = cyc;
    @(negedge clk);
    de       = 1'b1;
    pixel_in = 24'hFFFFFF;
    @(negedge clk);
    @(negedge clk);
    de       = 1'b0;
    pixel_in = '0;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_x_hold"}, 32'(x_center), exp_x);
    chk({tag, "_y_hold"}, 32'(y_center), exp_y);
    chk({tag, "_busy_idle"}, 32'(busy), 0);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        busy_len = 0;
      end else begin
        if (busy === 1'b1) begin
          busy_len++;
          busy_total++;
        end
        if (valid === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_valid: actual pulse at cycle %0d required none", cyc);
          end else begin
            e = sb.pop_front();
            chk("x_center", 32'(x_center), e.x);
            chk("y_center", 32'(y_center), e.y);
            chk("latency", cyc - e.fe, 66);
            chk("busy_cycles", busy_len, 65);
          end
          busy_len = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int bt;
    rst_n    = 1'b0;
    de       = 1'b0;
    hsync    = 1'b0;
    vsync    = 1'b0;
    pixel_in = '0;
    idle(3);
    chk("rst_x", 32'(x_center), 640);
    chk("rst_y", 32'(y_center), 360);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    idle(2);

    // 1: 20x20 square, fg exactly at threshold, bg one below (upper bits set)
    send_frame(120, 70, 100, 119, 50, 69, 24'h000080, 24'hFFFF7F, 1'b1);
    expect_update(109, 59);
    idle(80);
    chk_hold("t1");

    // 2: nothing at or above threshold
    bt = busy_total;
    send_frame(120, 70, 100, 119, 50, 69, 24'hFFFF7F, 24'h000000, 1'b0);
    idle(80);
    chk_hold("t2");
    chk("t2_no_busy", busy_total, bt);

    // 3: full 128x64 frame of 0xFFFFFF
    send_frame(128, 64, 0, 127, 0, 63, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    expect_update(63, 31);
    idle(80);
    chk_hold("t3");

    // 3b: centroid beyond the active area saturates
    send_frame(1400, 751, 1336, 1399, 750, 750, 24'h0000FF, 24'h000000, 1'b1);
    expect_update(1367, 750);
    idle(80);
    chk_hold("t3b");

    // 4: 49 pixels is below MIN_PIXELS, then exactly 64 pixels
    send_frame(17, 17, 10, 16, 10, 16, 24'h0000FF, 24'h000000, 1'b1);
    idle(80);
    chk_hold("t4a");
    send_frame(8, 8, 0, 7, 0, 7, 24'h0000FF, 24'h000000, 1'b1);
    expect_update(3, 3);
    idle(80);
    chk_hold("t4b");

    // 5: reset during DIV_X
    send_frame(120, 70, 100, 119, 50, 69, 24'h0000FF, 24'h000000, 1'b1);
    while (cyc < last_fe + 20) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_x", 32'(x_center), 640);
    chk("t5_rst_y", 32'(y_center), 360);
    chk("t5_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(80);
    chk_hold("t5a");
    send_frame(120, 70, 100, 119, 50, 69, 24'h0000FF, 24'h000000, 1'b1);
    expect_update(109, 59);
    idle(80);
    chk_hold("t5b");

    // 6: second square after (109,59)
    send_frame(520, 270, 500, 519, 250, 269, 24'h0000FF, 24'h000000, 1'b1);
    expect_update(509, 259);
    idle(80);
    chk_hold("t6");

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
